// File: rtl/aes_pkg.sv
// Shared AES types, round constants and word helpers.
// Used by the key schedule blocks.
package aes_pkg;

    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_key_t;

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } inv_ks_state_t;

    localparam logic [7:0] AES_RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic aes_word_t rot_word(input aes_word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte, purely combinational.
// Shared with the forward key schedule.
module aes_sbox (
    input  logic [7:0] x,
    output logic [7:0] y
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y = SBOX[x];

endmodule

// File: rtl/aes_inv_key_schedule.sv
// AES-128 inverse key expansion: walks round keys 10 down to 0,
// one per valid/ready handshake.
module aes_inv_key_schedule
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         busy,
    output logic         done
);

    inv_ks_state_t state_q, state_d;
    aes_key_t      key_q;
    logic [3:0]    round_q;
    logic          done_q;

    logic          accept;
    logic          last;
    logic          load;

    aes_word_t     wa, wb, wc, wd;
    aes_word_t     na, nb, nc, nd;
    aes_word_t     rot, sub;
    logic [7:0]    rcon;

    assign accept = (state_q == ST_EMIT) && rk_ready;
    assign last   = (round_q == 4'd0);
    assign load   = (state_q == ST_IDLE) && start;

    assign wa = key_q[127:96];
    assign wb = key_q[95:64];
    assign wc = key_q[63:32];
    assign wd = key_q[31:0];

    // The newest three words come straight from xors of neighbours;
    // the first word then needs the already-recovered last word.
    assign nd  = wd ^ wc;
    assign nc  = wc ^ wb;
    assign nb  = wb ^ wa;
    assign rot = rot_word(nd);

    for (genvar i = 0; i < 4; i++) begin : g_sub
        aes_sbox u_sbox (
            .x (rot[8*i +: 8]),
            .y (sub[8*i +: 8])
        );
    end

    // Round constant for the key being stepped back from.
    always_comb begin
        rcon = 8'h00;
        if (round_q >= 4'd1 && round_q <= 4'd10) begin
            rcon = AES_RCON[round_q];
        end
    end

    assign na = wa ^ sub ^ {rcon, 24'h000000};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at while idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_EMIT;
            ST_EMIT: if (accept && last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from state.
    always_comb begin
        rk_valid = 1'b0;
        busy     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                rk_valid = 1'b0;
                busy     = 1'b0;
            end
            ST_EMIT: begin
                rk_valid = 1'b1;
                busy     = 1'b1;
            end
            default: begin
                rk_valid = 1'b0;
                busy     = 1'b0;
            end
        endcase
    end

    // Key and round register: load, then step back on each accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q   <= '0;
            round_q <= 4'd0;
        end else if (load) begin
            key_q   <= key_in;
            round_q <= 4'd10;
        end else if (accept && !last) begin
            key_q   <= {na, nb, nc, nd};
            round_q <= round_q - 4'd1;
        end
    end

    // Registered one-cycle completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= accept && last;
        end
    end

    assign rk_out   = key_q;
    assign rk_round = round_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Bench for the inverse key schedule against a word-level
// AES key expansion model with a GF(2^8)-derived S-box.
module tb_aes_inv_key_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    logic [7:0]   inv_tab [256];
    logic [127:0] rk_exp  [11];

    localparam logic [127:0] FIPS10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FIPS9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] FIPS0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    always #5 clk = ~clk;

    aes_inv_key_schedule dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_round (rk_round),
        .busy     (busy),
        .done     (done)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_m(input logic [7:0] v);
        logic [7:0] b = inv_tab[v];
        logic [7:0] r = b;
        logic [7:0] s = b;
        for (int k = 0; k < 4; k++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon_m(input int i);
        logic [7:0] r = 8'h01;
        for (int k = 1; k < i; k++) r = gmul(r, 8'h02);
        return r;
    endfunction

    function automatic logic [31:0] g_m(input logic [31:0] prev, input int i);
        logic [31:0] t;
        if (i % 4 != 0) return prev;
        t = {prev[23:0], prev[31:24]};
        t = {sbox_m(t[31:24]), sbox_m(t[23:16]), sbox_m(t[15:8]), sbox_m(t[7:0])};
        return t ^ {rcon_m(i / 4), 24'h000000};
    endfunction

    task automatic build_inv();
        inv_tab[0] = 8'h00;
        for (int x = 1; x < 256; x++)
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv_tab[x] = 8'(y);
    endtask

    task automatic expand_fwd(input logic [127:0] k);
        logic [31:0] w [44];
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) w[i] = w[i-4] ^ g_m(w[i-1], i);
        for (int r = 0; r < 11; r++) rk_exp[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic model_inv(input logic [127:0] k10);
        logic [31:0] w [44];
        for (int i = 0; i < 4; i++) w[40+i] = k10[127-32*i -: 32];
        for (int i = 43; i >= 4; i--) w[i-4] = w[i] ^ g_m(w[i-1], i);
        for (int r = 0; r < 11; r++) rk_exp[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic pulse_start(input logic [127:0] k);
        @(negedge clk);
        start  = 1'b1;
        key_in = k;
        @(negedge clk);
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (rk_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rk_valid); end
        total++; if (rk_out !== '0) begin bad++; $display("FAIL reset_out got=%h exp=0", rk_out); end
        total++; if (rk_round !== 4'd0) begin bad++; $display("FAIL reset_round got=%0d exp=0", rk_round); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (rk_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b exp=0", rk_valid); end
    endtask

    task automatic test_fips();
        rk_ready = 1'b1;
        model_inv(FIPS10);
        pulse_start(FIPS10);
        for (int r = 10; r >= 0; r--) begin
            total++; if (rk_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL fips_valid r=%0d got=%b%b exp=11", r, rk_valid, busy); end
            total++; if (rk_round !== 4'(r)) begin bad++; $display("FAIL fips_round got=%0d exp=%0d", rk_round, r); end
            total++; if (rk_out !== rk_exp[r]) begin bad++; $display("FAIL fips_key r=%0d got=%h exp=%h", r, rk_out, rk_exp[r]); end
            if (r == 10) begin total++; if (rk_out !== FIPS10) begin bad++; $display("FAIL fips_r10 got=%h exp=%h", rk_out, FIPS10); end end
            if (r == 9) begin total++; if (rk_out !== FIPS9) begin bad++; $display("FAIL fips_r9 got=%h exp=%h", rk_out, FIPS9); end end
            if (r == 0) begin total++; if (rk_out !== FIPS0) begin bad++; $display("FAIL fips_r0 got=%h exp=%h", rk_out, FIPS0); end end
            @(negedge clk);
        end
        total++; if ({done, busy, rk_valid} !== 3'b100) begin bad++; $display("FAIL fips_done got=%b exp=100", {done, busy, rk_valid}); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL fips_done_width got=%b exp=0", done); end
    endtask

    task automatic test_backpressure();
        int exp_r = 10;
        int hs = 0;
        logic stalled = 1'b0;
        logic [127:0] prev_out = '0;
        logic [3:0] prev_round = '0;
        model_inv(FIPS10);
        pulse_start(FIPS10);
        for (int cyc = 0; cyc < 300 && hs < 11; cyc++) begin
            if (stalled) begin
                total++; if (rk_out !== prev_out || rk_round !== prev_round) begin bad++; $display("FAIL bp_stable got=%h/%0d exp=%h/%0d", rk_out, rk_round, prev_out, prev_round); end
            end
            total++; if (rk_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b exp=1", rk_valid); end
            total++; if (rk_round !== 4'(exp_r) || rk_out !== rk_exp[exp_r]) begin bad++; $display("FAIL bp_key got=%0d/%h exp=%0d/%h", rk_round, rk_out, exp_r, rk_exp[exp_r]); end
            rk_ready = 1'($urandom % 2);
            stalled = !rk_ready;
            prev_out = rk_out;
            prev_round = rk_round;
            if (rk_ready) begin hs++; exp_r--; end
            @(negedge clk);
        end
        total++; if (hs !== 11) begin bad++; $display("FAIL bp_handshakes got=%0d exp=11", hs); end
        total++; if (done !== 1'b1 || rk_valid !== 1'b0) begin bad++; $display("FAIL bp_done got=%b%b exp=10", done, rk_valid); end
        rk_ready = 1'b1;
    endtask

    task automatic test_start_while_busy();
        rk_ready = 1'b1;
        expand_fwd({$urandom, $urandom, $urandom, $urandom});
        pulse_start(rk_exp[10]);
        for (int r = 10; r >= 0; r--) begin
            total++; if (rk_round !== 4'(r) || rk_out !== rk_exp[r]) begin bad++; $display("FAIL swb_key got=%0d/%h exp=%0d/%h", rk_round, rk_out, r, rk_exp[r]); end
            start = (r == 5);
            key_in = ~rk_exp[10];
            @(negedge clk);
        end
        start = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL swb_done got=%b exp=1", done); end
        @(negedge clk);
        total++; if (rk_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL swb_noload got=%b%b exp=00", rk_valid, busy); end
    endtask

    task automatic test_reset_mid();
        rk_ready = 1'b1;
        expand_fwd({$urandom, $urandom, $urandom, $urandom});
        pulse_start(rk_exp[10]);
        for (int r = 10; r > 4; r--) @(negedge clk);
        total++; if (rk_round !== 4'd4) begin bad++; $display("FAIL rst_mid_round got=%0d exp=4", rk_round); end
        #2 rst = 1'b1;
        #1;
        total++; if ({rk_valid, busy, done, rk_round} !== 7'd0 || rk_out !== '0) begin bad++; $display("FAIL rst_mid_clear got=%b%b%b/%0d/%h exp=0", rk_valid, busy, done, rk_round, rk_out); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (rk_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_idle got=%b exp=0", rk_valid); end
        pulse_start(rk_exp[10]);
        for (int r = 10; r >= 0; r--) begin
            total++; if (rk_round !== 4'(r) || rk_out !== rk_exp[r]) begin bad++; $display("FAIL rst_restart got=%0d/%h exp=%0d/%h", rk_round, rk_out, r, rk_exp[r]); end
            @(negedge clk);
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL rst_restart_done got=%b exp=1", done); end
    endtask

    task automatic test_back_to_back();
        rk_ready = 1'b1;
        expand_fwd({$urandom, $urandom, $urandom, $urandom});
        pulse_start(rk_exp[10]);
        for (int r = 10; r >= 0; r--) begin
            total++; if (rk_round !== 4'(r) || rk_out !== rk_exp[r]) begin bad++; $display("FAIL b2b_first got=%0d/%h exp=%0d/%h", rk_round, rk_out, r, rk_exp[r]); end
            @(negedge clk);
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b exp=1", done); end
        start = 1'b1;
        key_in = '0;
        @(negedge clk);
        start = 1'b0;
        model_inv('0);
        for (int r = 10; r >= 0; r--) begin
            total++; if (rk_valid !== 1'b1 || rk_round !== 4'(r) || rk_out !== rk_exp[r]) begin bad++; $display("FAIL b2b_second got=%b/%0d/%h exp=1/%0d/%h", rk_valid, rk_round, rk_out, r, rk_exp[r]); end
            @(negedge clk);
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done2 got=%b exp=1", done); end
    endtask

    task automatic test_random();
        rk_ready = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            expand_fwd({$urandom, $urandom, $urandom, $urandom});
            pulse_start(rk_exp[10]);
            for (int r = 10; r >= 0; r--) begin
                total++; if (rk_round !== 4'(r) || rk_out !== rk_exp[r]) begin bad++; $display("FAIL rand_key n=%0d got=%0d/%h exp=%0d/%h", n, rk_round, rk_out, r, rk_exp[r]); end
                @(negedge clk);
            end
            total++; if (done !== 1'b1) begin bad++; $display("FAIL rand_done n=%0d got=%b exp=1", n, done); end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        rk_ready = 1'b0;
        key_in = '0;
        build_inv();
        test_reset();
        test_fips();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
